// File: rtl/fp_div_norm_seq.sv
// Post-divide normalizer: left-normalizes a quotient, rounds it and flags zero/ovf/unf/inexact.
// Optional macro FP_DIV_NORM_ROUND_EN selects round-to-nearest-even; otherwise the fraction truncates.
module fp_div_norm_seq #(
   parameter int unsigned EXP_WIDTH  = 11,
   parameter int unsigned MANT_WIDTH = 52
) (
   input  logic                  in_Clk,
   input  logic                  in_RstN,
   input  logic                  in_Valid,
   output logic                  out_InReady,
   input  logic [EXP_WIDTH-1:0]  in_Exp,
   input  logic [MANT_WIDTH+2:0] in_Mant,
   output logic                  out_Valid,
   input  logic                  in_OutReady,
   output logic [EXP_WIDTH-1:0]  out_Exp,
   output logic [MANT_WIDTH-1:0] out_Mant,
   output logic                  out_Zero,
   output logic                  out_Ovf,
   output logic                  out_Unf,
   output logic                  out_Inexact
);

   localparam int unsigned MW = MANT_WIDTH + 3;
   localparam int unsigned SW = MANT_WIDTH + 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [EXP_WIDTH-1:0]  exp_q, exp_d;
   logic [MW-1:0]         mant_q, mant_d;
   logic                  ready_q, ready_d;
   logic                  valid_q, valid_d;
   logic [EXP_WIDTH-1:0]  oexp_q, oexp_d;
   logic [MANT_WIDTH-1:0] omant_q, omant_d;
   logic                  ozero_q, ozero_d;
   logic                  oovf_q, oovf_d;
   logic                  ounf_q, ounf_d;
   logic                  oinx_q, oinx_d;

   logic                  rnd_inc;
   logic [SW-1:0]         rnd_sig;
   logic                  rnd_carry;
   logic                  rnd_hidden;
   logic [EXP_WIDTH-1:0]  rnd_exp;
   logic [MANT_WIDTH-1:0] rnd_frac;
   logic                  shift_en;

   // Rounding datapath on {hidden, fraction}; a carry out renormalizes to 1.0 x 2^(exp+1)
   always_comb begin
`ifdef FP_DIV_NORM_ROUND_EN
      rnd_inc = mant_q[1] & (mant_q[0] | mant_q[2]);
`else
      rnd_inc = 1'b0;
`endif
      rnd_sig    = {1'b0, mant_q[MW-1:2]} + SW'(rnd_inc);
      rnd_carry  = rnd_sig[SW-1];
      rnd_hidden = rnd_sig[MANT_WIDTH];
      rnd_exp    = rnd_carry ? exp_q + EXP_WIDTH'(1) : exp_q;
      rnd_frac   = rnd_carry ? '0 : rnd_sig[MANT_WIDTH-1:0];
   end

   // An all-ones exponent is already an overflow, so it is never shifted down
   assign shift_en = ~mant_q[MW-1] & (|mant_q) & (exp_q > EXP_WIDTH'(1)) & (exp_q != '1);

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      mant_d  = mant_q;
      valid_d = valid_q;
      oexp_d  = oexp_q;
      omant_d = omant_q;
      ozero_d = ozero_q;
      oovf_d  = oovf_q;
      ounf_d  = ounf_q;
      oinx_d  = oinx_q;

      case (state_q)
         S_IDLE: begin
            if (in_Valid && ready_q) begin
               exp_d   = (in_Exp == '0) ? EXP_WIDTH'(1) : in_Exp;
               mant_d  = in_Mant;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (shift_en) begin
               mant_d = {mant_q[MW-2:1], 1'b0, mant_q[0]};
               exp_d  = exp_q - EXP_WIDTH'(1);
            end else begin
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            valid_d = 1'b1;
            state_d = S_DONE;
            oinx_d  = mant_q[1] | mant_q[0];
            ozero_d = 1'b0;
            oovf_d  = 1'b0;
            ounf_d  = 1'b0;
            if (mant_q == '0) begin
               oexp_d  = '0;
               omant_d = '0;
               ozero_d = 1'b1;
            end else if ((exp_q == '1) || (rnd_exp == '1)) begin
               oexp_d  = '1;
               omant_d = '0;
               oovf_d  = 1'b1;
            end else if (!rnd_carry && !rnd_hidden) begin
               oexp_d  = '0;
               omant_d = rnd_frac;
               ounf_d  = 1'b1;
            end else begin
               oexp_d  = rnd_exp;
               omant_d = rnd_frac;
            end
         end
         S_DONE: begin
            if (in_OutReady) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge in_Clk or negedge in_RstN) begin
      if (!in_RstN) begin
         state_q <= S_IDLE;
         exp_q   <= '0;
         mant_q  <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         oexp_q  <= '0;
         omant_q <= '0;
         ozero_q <= 1'b0;
         oovf_q  <= 1'b0;
         ounf_q  <= 1'b0;
         oinx_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         mant_q  <= mant_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         oexp_q  <= oexp_d;
         omant_q <= omant_d;
         ozero_q <= ozero_d;
         oovf_q  <= oovf_d;
         ounf_q  <= ounf_d;
         oinx_q  <= oinx_d;
      end
   end

   assign out_InReady = ready_q;
   assign out_Valid   = valid_q;
   assign out_Exp     = oexp_q;
   assign out_Mant    = omant_q;
   assign out_Zero    = ozero_q;
   assign out_Ovf     = oovf_q;
   assign out_Unf     = ounf_q;
   assign out_Inexact = oinx_q;

endmodule

// File: tb/tb_fp_div_norm_seq.sv
// Bench for fp_div_norm_seq (EXP_WIDTH=8, MANT_WIDTH=23): directed table, reset/hold sequence, random vs model.
module tb_fp_div_norm_seq;

   localparam int unsigned EW = 8;
   localparam int unsigned MWD = 23;
`ifdef FP_DIV_NORM_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   typedef struct packed {
      logic [7:0]  exp;
      logic [22:0] mant;
      logic        zero;
      logic        ovf;
      logic        unf;
      logic        inx;
      int          lat;
   } res_t;

   typedef struct packed {
      logic [7:0]  e;
      logic [25:0] m;
      res_t        r;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [EW-1:0] in_exp;
   logic [MWD+2:0] in_mant;
   logic          out_valid;
   logic          out_ready;
   logic [EW-1:0] out_exp;
   logic [MWD-1:0] out_mant;
   logic          out_zero, out_ovf, out_unf, out_inx;

   int checks = 0;
   int errors = 0;

   fp_div_norm_seq #(.EXP_WIDTH(EW), .MANT_WIDTH(MWD)) dut (
      .in_Clk(clk), .in_RstN(rst_n), .in_Valid(in_valid), .out_InReady(in_ready),
      .in_Exp(in_exp), .in_Mant(in_mant), .out_Valid(out_valid), .in_OutReady(out_ready),
      .out_Exp(out_exp), .out_Mant(out_mant), .out_Zero(out_zero), .out_Ovf(out_ovf),
      .out_Unf(out_unf), .out_Inexact(out_inx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [34:0] pk(input res_t r);
      return {r.exp, r.mant, r.zero, r.ovf, r.unf, r.inx};
   endfunction

   function automatic logic [34:0] dut_pk();
      return {out_exp, out_mant, out_zero, out_ovf, out_unf, out_inx};
   endfunction

   // Reference: normalize as a number (value above sticky doubles), round, then classify
   function automatic res_t model(input logic [7:0] ein, input logic [25:0] min);
      res_t   r;
      longint m, q;
      int     e;
      bit     g, s, l, inc;
      r = '0;
      r.lat = 2;
      if (min == 0) begin
         r.zero = 1'b1;
         return r;
      end
      e = (ein == 0) ? 1 : int'(ein);
      m = longint'(min);
      if (e != 255)
         while (m < (64'd1 << 25) && e > 1) begin
            m = (m >> 1) * 4 + m % 2;
            e--;
            r.lat++;
         end
      g = m[1];
      s = m[0];
      l = m[2];
      inc = RND && g && (s || l);
      r.inx = g | s;
      q = (m >> 2) + longint'(inc);
      if (q >= (64'd1 << 24)) begin
         q = 64'd1 << 23;
         e++;
      end
      if (e >= 255) begin
         r.exp = 8'hFF; r.mant = '0; r.ovf = 1'b1;
      end else if (q < (64'd1 << 23)) begin
         r.exp = 8'h00; r.mant = 23'(q); r.unf = 1'b1;
      end else begin
         r.exp = 8'(e); r.mant = 23'(q - (64'd1 << 23));
      end
      return r;
   endfunction

   function automatic vec_t mk(input logic [7:0] e, input logic [25:0] m, input logic [7:0] xe,
                               input logic [22:0] xm, input logic z, input logic o,
                               input logic u, input logic i, input int lat);
      vec_t v;
      v.e = e; v.m = m;
      v.r.exp = xe; v.r.mant = xm; v.r.zero = z; v.r.ovf = o; v.r.unf = u; v.r.inx = i;
      v.r.lat = lat;
      return v;
   endfunction

   // One transaction: wait for ready, accept, measure latency, check result, hold, release
   task automatic run_op(input logic [7:0] e, input logic [25:0] m, input res_t r,
                         input int hold, input string tag);
      int lat;
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, " ready_before"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_exp   = e;
      in_mant  = m;
      @(posedge clk); #1;
      in_exp  = 8'($urandom);
      in_mant = 26'($urandom);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'(r.lat));
      chk({tag, " result"}, 64'(dut_pk()), 64'(pk(r)));
      chk({tag, " busy_ready"}, 64'(in_ready), 64'd0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk({tag, " held"}, 64'({out_valid, dut_pk()}), 64'({1'b1, pk(r)}));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, " valid_drop"}, 64'(out_valid), 64'd0);
      chk({tag, " ready_after"}, 64'(in_ready), 64'd1);
   endtask

   vec_t vecs[13];

   initial begin
      int   seen;
      res_t r;
      logic [7:0]  re;
      logic [25:0] rm;

      vecs[0]  = mk(8'd127, 26'h2000000, 8'd127, 23'h0,      0, 0, 0, 0, 2);
      vecs[1]  = mk(8'd127, 26'h1000000, 8'd126, 23'h0,      0, 0, 0, 0, 3);
      vecs[2]  = mk(8'd127, 26'h2000006, 8'd127, RND ? 23'h2 : 23'h1, 0, 0, 0, 1, 2);
      if (RND) vecs[3] = mk(8'hFE, 26'h3FFFFFE, 8'hFF, 23'h0, 0, 1, 0, 1, 2);
      else     vecs[3] = mk(8'hFE, 26'h3FFFFFE, 8'hFE, 23'h7FFFFF, 0, 0, 0, 1, 2);
      vecs[4]  = mk(8'd3,   26'h0400000, 8'd0,   23'h400000, 0, 0, 1, 0, 4);
      vecs[5]  = mk(8'd50,  26'h0000000, 8'd0,   23'h0,      1, 0, 0, 0, 2);
      vecs[6]  = mk(8'hFF,  26'h2000000, 8'hFF,  23'h0,      0, 1, 0, 0, 2);
      vecs[7]  = mk(8'd0,   26'h2000000, 8'd1,   23'h0,      0, 0, 0, 0, 2);
      if (RND) vecs[8] = mk(8'd1, 26'h1FFFFFE, 8'd1, 23'h0, 0, 0, 0, 1, 2);
      else     vecs[8] = mk(8'd1, 26'h1FFFFFE, 8'd0, 23'h7FFFFF, 0, 0, 1, 1, 2);
      vecs[9]  = mk(8'd5,   26'h0000001, 8'd0,   23'h0,      0, 0, 1, 1, 6);
      vecs[10] = mk(8'd100, 26'h2000002, 8'd100, 23'h0,      0, 0, 0, 1, 2);
      vecs[11] = mk(8'd10,  26'h0000100, 8'd0,   23'h008000, 0, 0, 1, 0, 11);
      vecs[12] = mk(8'd50,  26'h0800003, 8'd48,  23'h000002, 0, 0, 0, 1, 4);

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_exp = '0; in_mant = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset outputs", 64'({out_valid, dut_pk()}), 64'd0);
      chk("reset ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready after release", 64'(in_ready), 64'd1);

      foreach (vecs[i])
         run_op(vecs[i].e, vecs[i].m, vecs[i].r, (i == 0) ? 5 : i % 3, $sformatf("vec%0d", i));

      // Reset mid-SHIFT: operand is dropped and outputs clear asynchronously
      @(negedge clk);
      in_valid = 1'b1; in_exp = 8'd127; in_mant = 26'h0000400;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("abort outputs", 64'({out_valid, dut_pk()}), 64'd0);
      chk("abort ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort ready after release", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("abort no result", 64'(seen), 64'd0);

      for (int n = 0; n < 40; n++) begin
         re = 8'($urandom_range(0, 255));
         rm = 26'($urandom) >> $urandom_range(0, 25);
         if (n % 13 == 0) rm = '0;
         r = model(re, rm);
         run_op(re, rm, r, $urandom_range(0, 3), $sformatf("rnd%0d e=%0h m=%0h", n, re, rm));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_div_norm_seq.md
FP_DIV_NORM_SEQ -- requirements
Module: fp_div_norm_seq

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 11, biased exponent width.
REQ-002 SHALL have parameter MANT_WIDTH, default 52, stored fraction width, hidden bit excluded.
REQ-003 SHALL have port in_Clk, input, 1, single clock, rising edge.
REQ-004 SHALL have port in_RstN, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port in_Valid, input, 1, input operand valid.
REQ-006 SHALL have port out_InReady, output, 1, block can accept an operand.
REQ-007 SHALL have port in_Exp, input, EXP_WIDTH, biased quotient exponent.
REQ-008 SHALL have port in_Mant, input, MANT_WIDTH+3, quotient: [MANT_WIDTH+2] weight 2^0, [MANT_WIDTH+1:2] fraction, [1] guard, [0] sticky.
REQ-009 SHALL have port out_Valid, output, 1, result valid.
REQ-010 SHALL have port in_OutReady, input, 1, consumer accepts the result.
REQ-011 SHALL have port out_Exp, output, EXP_WIDTH, result exponent.
REQ-012 SHALL have port out_Mant, output, MANT_WIDTH, result fraction.
REQ-013 SHALL have port out_Zero / out_Ovf / out_Unf / out_Inexact, output, 1 each, result flags.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, ROUND, DONE; out_InReady=1 only in IDLE.
REQ-015 SHALL accept when in_Valid && out_InReady at a rising edge: load exponent and mantissa registers (in_Exp==0 loaded as 1), go to SHIFT.
REQ-016 In SHIFT, each cycle with mant[MSB]==0, mant!=0 and exp>1 SHALL shift bits [MANT_WIDTH+2:1] left by one (0 in at bit 1, sticky bit 0 held) and decrement exp; otherwise go to ROUND.
REQ-017 ROUND SHALL compute G=bit1, S=bit0, L=bit2, set out_Inexact=G|S, apply the rounding rule (REQ-029/030), then go to DONE.
REQ-018 Rounding carry into bit MANT_WIDTH+3 SHALL clear the fraction and increment exp; carry into the hidden bit of a subnormal SHALL give exp=1, out_Unf=0.
REQ-019 If the final exp == all-ones (including in_Exp all-ones at acceptance), the block SHALL output out_Exp all-ones, out_Mant=0, out_Ovf=1.
REQ-020 If the mantissa is zero, the block SHALL output out_Zero=1, out_Exp=0, out_Mant=0, with no shifting.
REQ-021 If SHIFT stops with exp==1 and mant[MSB]==0 (nonzero), the block SHALL output out_Exp=0, out_Unf=1.
REQ-022 Normal results SHALL output out_Exp=exp and out_Mant=mant[MANT_WIDTH+1:2].
REQ-023 Latency SHALL be k+2 rising edges from the accept edge to out_Valid high, k=number of shifts.
REQ-024 In DONE, out_Valid=1 and all outputs SHALL be held stable until in_OutReady=1; that edge returns to IDLE, one bubble cycle minimum between results.
REQ-025 in_Valid/in_Exp/in_Mant outside IDLE SHALL be ignored.

Reset
REQ-026 in_RstN low SHALL immediately force IDLE, clear out_Valid, out_Exp, out_Mant and all flags to 0.
REQ-027 Reset mid-operation SHALL discard the operand; no result for it is ever produced.
REQ-028 out_InReady SHALL be 0 while in_RstN is low and 1 in the first cycle after release.

Configuration
REQ-029 With macro FP_DIV_NORM_ROUND_EN defined, ROUND SHALL apply round-to-nearest-even: increment when G && (S || L).
REQ-030 Without FP_DIV_NORM_ROUND_EN, ROUND SHALL truncate (no increment, no carry path); out_Inexact still reported.

Verification (EXP_WIDTH=8, MANT_WIDTH=23)
REQ-031 in_Exp=8'd127, in_Mant=26'h2000000 -> out_Valid 2 edges after accept, out_Exp=127, out_Mant=0, flags 0.
REQ-032 in_Exp=8'd127, in_Mant=26'h1000000 -> latency 3, out_Exp=126, out_Mant=0.
REQ-033 in_Exp=8'd127, in_Mant=26'h2000006 -> out_Mant=23'h000002 with ROUND_EN, 23'h000001 without; out_Inexact=1 both.
REQ-034 in_Exp=8'hFE, in_Mant=26'h3FFFFFE, ROUND_EN -> out_Exp=8'hFF, out_Mant=0, out_Ovf=1.
REQ-035 in_Exp=8'd3, in_Mant=26'h0400000 -> 2 shifts, latency 4, out_Exp=0, out_Mant=23'h400000, out_Unf=1.
REQ-036 Hold in_OutReady=0 for 5 cycles in DONE, then pulse in_RstN low mid-SHIFT on next operand -> outputs stable while held, zeroed at reset, no result for aborted operand.
